// File: rtl/frac_baud_gen_if.sv
// Control/status bundle for frac_baud_gen: divisor programming, enable/sync
// controls, and the registered tick outputs.
interface frac_baud_gen_if #(
    parameter int DVSR_W = 11,
    parameter int FRAC_W = 4
);
    // Handshake: dvsr_wr is a one-cycle strobe with no ready; the divisor write
    // is always accepted into the shadow on the edge that samples it, in any state.
    logic              en;
    logic [DVSR_W-1:0] dvsr_int;
    logic [FRAC_W-1:0] dvsr_frac;
    logic              dvsr_wr;
    logic              sync_clr;
    logic              tick;
    logic              bit_tick;
    logic              active;
    logic              state_dbg;

    modport master (
        output en, dvsr_int, dvsr_frac, dvsr_wr, sync_clr,
        input  tick, bit_tick, active, state_dbg
    );

    modport slave (
        input  en, dvsr_int, dvsr_frac, dvsr_wr, sync_clr,
        output tick, bit_tick, active, state_dbg
    );
endinterface

// File: rtl/frac_baud_gen.sv
// Fractional baud tick generator: average oversample period (N+1)+F/2^FRAC_W
// clocks, a bit_tick every OVS ticks, and a shadowed divisor applied at period end.
module frac_baud_gen #(
    parameter int DVSR_W       = 11,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int DEFAULT_INT  = 650,
    parameter int DEFAULT_FRAC = 1
) (
    input  logic           clk,
    input  logic           reset,
    frac_baud_gen_if.slave bus
);
    localparam int SUB_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVS - 1);
    localparam logic [DVSR_W-1:0] INT_RST  = DVSR_W'(DEFAULT_INT);
    localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'(DEFAULT_FRAC);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DVSR_W-1:0] int_sh_q, int_sh_d;
    logic [FRAC_W-1:0] frac_sh_q, frac_sh_d;
    logic [DVSR_W-1:0] int_act_q, int_act_d;
    logic [FRAC_W-1:0] frac_act_q, frac_act_d;
    logic              tick_q, tick_d;
    logic              bit_tick_q, bit_tick_d;

    // One extra bit so int_act at its maximum plus a stretch cannot overflow.
    logic [DVSR_W:0]   limit;
    logic [FRAC_W:0]   acc_sum;
    logic              wrap;

    assign limit   = {1'b0, int_act_q} + {{DVSR_W{1'b0}}, ext_q};
    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_act_q};
    assign wrap    = ({1'b0, cnt_q} == limit);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            ext_q      <= 1'b0;
            sub_q      <= '0;
            int_sh_q   <= INT_RST;
            frac_sh_q  <= FRAC_RST;
            int_act_q  <= INT_RST;
            frac_act_q <= FRAC_RST;
            tick_q     <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ext_q      <= ext_d;
            sub_q      <= sub_d;
            int_sh_q   <= int_sh_d;
            frac_sh_q  <= frac_sh_d;
            int_act_q  <= int_act_d;
            frac_act_q <= frac_act_d;
            tick_q     <= tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ext_d      = ext_q;
        sub_d      = sub_q;
        int_sh_d   = int_sh_q;
        frac_sh_d  = frac_sh_q;
        int_act_d  = int_act_q;
        frac_act_d = frac_act_q;
        tick_d     = 1'b0;
        bit_tick_d = 1'b0;

        if (bus.dvsr_wr) begin
            int_sh_d  = bus.dvsr_int;
            frac_sh_d = bus.dvsr_frac;
        end

        case (state_q)
            S_IDLE: begin
                int_act_d  = int_sh_q;
                frac_act_d = frac_sh_q;
                cnt_d      = '0;
                acc_d      = '0;
                ext_d      = 1'b0;
                sub_d      = '0;
                if (bus.en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ext_d   = 1'b0;
                    sub_d   = '0;
                end else if (bus.sync_clr) begin
                    // Phase restart only; the active divisor keeps its value.
                    cnt_d = '0;
                    acc_d = '0;
                    ext_d = 1'b0;
                    sub_d = '0;
                end else if (wrap) begin
                    cnt_d        = '0;
                    tick_d       = 1'b1;
                    {ext_d, acc_d} = acc_sum;
                    int_act_d    = int_sh_q;
                    frac_act_d   = frac_sh_q;
                    bit_tick_d   = (sub_q == SUB_LAST);
                    sub_d        = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.tick      = tick_q;
        bus.bit_tick  = bit_tick_q;
        bus.active    = (state_q == S_RUN);
        bus.state_dbg = state_q;
    end
endmodule

// File: tb/tb_frac_baud_gen.sv
// Directed bench for frac_baud_gen (N/F/OVS scenarios with hand-computed periods).
module tb_frac_baud_gen;
    localparam int DVSR_W = 11;
    localparam int FRAC_W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    frac_baud_gen_if #(.DVSR_W(DVSR_W), .FRAC_W(FRAC_W)) bus ();

    frac_baud_gen #(
        .DVSR_W(DVSR_W), .FRAC_W(FRAC_W), .OVS(4),
        .DEFAULT_INT(650), .DEFAULT_FRAC(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim did not finish got timeout want finish");
        $fatal(1);
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_dvsr(input int n, input int f);
        bus.dvsr_int  = DVSR_W'(n);
        bus.dvsr_frac = FRAC_W'(f);
        bus.dvsr_wr   = 1'b1;
        step();
        bus.dvsr_wr   = 1'b0;
    endtask

    // Steps until tick is seen; n == budget with no tick means it timed out.
    task automatic wait_tick(output int n, input int budget);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tick !== 1'b1 && n < budget);
    endtask

    task automatic restart(input int n, input int f);
        bus.en = 1'b0;
        write_dvsr(n, f);
        step();
        bus.en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.tick !== 1'b0 || bus.bit_tick !== 1'b0 || bus.active !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b want 000", bus.tick, bus.bit_tick, bus.active);
        end
        checks++;
        if (bus.state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got %b want 0", bus.state_dbg);
        end
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.tick !== 1'b0 || bus.active !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs got %b%b want 00", bus.tick, bus.active);
        end
    endtask

    task automatic test_basic();
        int n;
        restart(3, 0);
        checks++;
        if (bus.active !== 1'b1 || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL basic_entry got active=%b tick=%b want 1 0", bus.active, bus.tick);
        end
        for (int k = 1; k <= 8; k++) begin
            wait_tick(n, 20);
            checks++;
            if (n !== 4) begin
                errors++;
                $display("FAIL basic_period k=%0d got %0d want 4", k, n);
            end
            checks++;
            if (bus.bit_tick !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL basic_bit_tick k=%0d got %b want %b", k, bus.bit_tick, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_frac();
        int n;
        int exp_n;
        int total;
        total = 0;
        restart(3, 8);
        for (int i = 1; i <= 17; i++) begin
            wait_tick(n, 20);
            exp_n = (i >= 3 && (i % 2) == 1) ? 5 : 4;
            checks++;
            if (n !== exp_n) begin
                errors++;
                $display("FAIL frac_period i=%0d got %0d want %0d", i, n, exp_n);
            end
            if (i >= 2) total += n;
        end
        checks++;
        if (total !== 72) begin
            errors++;
            $display("FAIL frac_total16 got %0d want 72", total);
        end
    endtask

    task automatic test_n_zero();
        int n;
        int exp_n;
        restart(0, 8);
        for (int i = 1; i <= 6; i++) begin
            wait_tick(n, 10);
            exp_n = (i >= 3 && (i % 2) == 1) ? 2 : 1;
            checks++;
            if (n !== exp_n) begin
                errors++;
                $display("FAIL nzero_period i=%0d got %0d want %0d", i, n, exp_n);
            end
        end
    endtask

    task automatic test_dvsr_update();
        int n;
        restart(3, 0);
        wait_tick(n, 20);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL upd_first got %0d want 4", n);
        end
        step();
        write_dvsr(7, 0);
        wait_tick(n, 20);
        checks++;
        if (n + 2 !== 4) begin
            errors++;
            $display("FAIL upd_mid_cur got %0d want 4", n + 2);
        end
        wait_tick(n, 20);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL upd_mid_next got %0d want 8", n);
        end
        step();
        write_dvsr(3, 0);
        wait_tick(n, 20);
        checks++;
        if (n + 2 !== 8) begin
            errors++;
            $display("FAIL upd_back_cur got %0d want 8", n + 2);
        end
        wait_tick(n, 20);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL upd_back_next got %0d want 4", n);
        end
        repeat (3) step();
        write_dvsr(7, 0);
        checks++;
        if (bus.tick !== 1'b1) begin
            errors++;
            $display("FAIL upd_wrap_edge_tick got %b want 1", bus.tick);
        end
        wait_tick(n, 20);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL upd_wrap_next got %0d want 4", n);
        end
        wait_tick(n, 20);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL upd_wrap_after got %0d want 8", n);
        end
    endtask

    task automatic test_sync_clr();
        int n;
        restart(9, 0);
        for (int k = 1; k <= 2; k++) begin
            wait_tick(n, 20);
            checks++;
            if (n !== 10) begin
                errors++;
                $display("FAIL clr_pre k=%0d got %0d want 10", k, n);
            end
        end
        repeat (5) step();
        bus.sync_clr = 1'b1;
        step();
        bus.sync_clr = 1'b0;
        checks++;
        if (bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL clr_edge_tick got %b want 0", bus.tick);
        end
        for (int k = 1; k <= 4; k++) begin
            wait_tick(n, 20);
            checks++;
            if (n !== 10) begin
                errors++;
                $display("FAIL clr_period k=%0d got %0d want 10", k, n);
            end
            checks++;
            if (bus.bit_tick !== (k == 4)) begin
                errors++;
                $display("FAIL clr_bit_tick k=%0d got %b want %b", k, bus.bit_tick, k == 4);
            end
        end
    endtask

    task automatic test_enable();
        int n;
        int exp_n;
        restart(3, 8);
        for (int k = 1; k <= 2; k++) begin
            wait_tick(n, 20);
            checks++;
            if (n !== 4) begin
                errors++;
                $display("FAIL en_pre k=%0d got %0d want 4", k, n);
            end
        end
        repeat (2) step();
        bus.en = 1'b0;
        step();
        checks++;
        if (bus.tick !== 1'b0 || bus.bit_tick !== 1'b0 || bus.active !== 1'b0) begin
            errors++;
            $display("FAIL en_off got %b%b%b want 000", bus.tick, bus.bit_tick, bus.active);
        end
        step();
        bus.en       = 1'b1;
        bus.sync_clr = 1'b1;
        step();
        bus.sync_clr = 1'b0;
        checks++;
        if (bus.active !== 1'b1) begin
            errors++;
            $display("FAIL en_reentry_active got %b want 1", bus.active);
        end
        for (int i = 1; i <= 3; i++) begin
            wait_tick(n, 20);
            exp_n = (i == 3) ? 5 : 4;
            checks++;
            if (n !== exp_n) begin
                errors++;
                $display("FAIL en_restart i=%0d got %0d want %0d", i, n, exp_n);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        int k;
        k = 0;
        do begin
            wait_tick(n, 20);
            k++;
        end while (bus.bit_tick !== 1'b1 && k < 8);
        checks++;
        if (bus.bit_tick !== 1'b1) begin
            errors++;
            $display("FAIL arst_find_bit_tick got %b want 1", bus.bit_tick);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.tick !== 1'b0 || bus.bit_tick !== 1'b0 || bus.active !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate got %b%b%b want 000", bus.tick, bus.bit_tick, bus.active);
        end
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        bus.en = 1'b1;
        step();
        wait_tick(n, 700);
        checks++;
        if (n !== 651) begin
            errors++;
            $display("FAIL arst_default_period got %0d want 651", n);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.en        = 1'b0;
        bus.dvsr_int  = '0;
        bus.dvsr_frac = '0;
        bus.dvsr_wr   = 1'b0;
        bus.sync_clr  = 1'b0;
        test_reset();
        test_basic();
        test_frac();
        test_n_zero();
        test_dvsr_update();
        test_sync_clr();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
